// File: rtl/wake_pkg.sv
// ---------------------------------------------------------------------------
// wake_pkg
// Shared definitions for the wake-word recognizer and its command capture
// back end.
//   ASCII_W      width of one character on the shared ASCII stream
//   ASCII_CR/LF  common line terminators
//   cap_state_t  command capture FSM states
// ---------------------------------------------------------------------------
package wake_pkg;

  localparam int ASCII_W = 7;

  localparam logic [ASCII_W-1:0] ASCII_CR = 7'h0D;
  localparam logic [ASCII_W-1:0] ASCII_LF = 7'h0A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/wake_cmd_capture_if.sv
// ---------------------------------------------------------------------------
// wake_cmd_capture_if
// Bundles the ASCII stream inputs and the command output handshake of the
// wake_cmd_capture block.
//   ascii_in/ascii_vld/match  shared character stream plus recognizer match
//   cmd_char/cmd_valid/cmd_last/cmd_ready  command drain handshake
//   busy, err_ovf, err_tmo    status and error pulses
// Modports:
//   master  the environment: drives the stream and cmd_ready
//   slave   the capture block: drives the command and status outputs
// ---------------------------------------------------------------------------
interface wake_cmd_capture_if;
  import wake_pkg::*;

  logic [ASCII_W-1:0] ascii_in;
  logic               ascii_vld;
  logic               match;
  logic [ASCII_W-1:0] cmd_char;
  logic               cmd_valid;
  logic               cmd_last;
  logic               cmd_ready;
  logic               busy;
  logic               err_ovf;
  logic               err_tmo;

  modport master (
    output ascii_in, ascii_vld, match, cmd_ready,
    input  cmd_char, cmd_valid, cmd_last, busy, err_ovf, err_tmo
  );

  modport slave (
    input  ascii_in, ascii_vld, match, cmd_ready,
    output cmd_char, cmd_valid, cmd_last, busy, err_ovf, err_tmo
  );

endinterface

// File: rtl/cmd_char_buf.sv
// ---------------------------------------------------------------------------
// cmd_char_buf
// DEPTH x ASCII_W register file holding the captured command characters.
// One synchronous write port and one asynchronous read port. The storage has
// no reset: the capture FSM tracks how many entries are valid.
//   clk    clock, posedge
//   we     write enable
//   waddr  write address
//   wdata  character to store
//   raddr  read address
//   rdata  character at raddr (combinational)
// ---------------------------------------------------------------------------
module cmd_char_buf
  import wake_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ASCII_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ASCII_W-1:0] rdata
);

  logic [ASCII_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wake_cmd_capture.sv
// ---------------------------------------------------------------------------
// wake_cmd_capture
// Sits behind the "Alexa" wake-word recognizer on the same ASCII stream.
// Once the recognizer matches, the following characters are captured as a
// command until TERM arrives, then the command is drained one character per
// beat over a valid/ready handshake. Overlong commands and stalled captures
// are discarded with a one-cycle error pulse.
// Parameters:
//   MAX_LEN  max stored command characters (terminator excluded), >= 1
//   TERM     terminator character, never stored
//   TIMEOUT  idle cycles allowed in CAPTURE before aborting, >= 1
// Ports:
//   clk   clock, posedge
//   rst   synchronous active-high reset
//   bus   wake_cmd_capture_if.slave: stream in, command handshake and status out
// ---------------------------------------------------------------------------
module wake_cmd_capture
  import wake_pkg::*;
#(
  parameter int                 MAX_LEN = 16,
  parameter logic [ASCII_W-1:0] TERM    = ASCII_CR,
  parameter int                 TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  wake_cmd_capture_if.slave bus
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  cap_state_t         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_tmo_q, err_tmo_d;

  logic               buf_we;
  logic [ADDR_W-1:0]  buf_waddr;
  logic [ASCII_W-1:0] buf_rdata;
  logic               at_last;
  logic               is_term;

  assign is_term = (bus.ascii_in == TERM);

  // Only meaningful in DRAIN, where len_q is at least 1.
  assign at_last = (rd_ptr_q == (len_q - LEN_ONE));

  cmd_char_buf #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (bus.ascii_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (buf_rdata)
  );

  // State and counter registers. Reset drops any command in flight without
  // raising an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rd_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_ptr_q  <= rd_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  // Next-state logic. The character that arrives together with match is the
  // first command character, whether we were idle or already capturing.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_ptr_d  = rd_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    err_ovf_d = 1'b0;
    err_tmo_d = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = '0;

    case (state_q)
      IDLE: begin
        len_d     = '0;
        rd_ptr_d  = '0;
        tmo_cnt_d = '0;
        // A wake followed directly by TERM is an empty command: stay idle.
        if (bus.match && bus.ascii_vld && !is_term) begin
          buf_we  = 1'b1;
          len_d   = LEN_ONE;
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        if (bus.ascii_vld) begin
          tmo_cnt_d = '0;
          if (bus.match) begin
            // Re-wake: discard what was collected and restart the command.
            if (is_term) begin
              len_d = '0;
            end else begin
              buf_we = 1'b1;
              len_d  = LEN_ONE;
            end
          end else if (is_term) begin
            if (len_q == '0) begin
              state_d = IDLE;
            end else begin
              state_d  = DRAIN;
              rd_ptr_d = '0;
            end
          end else if (len_q < LEN_MAX) begin
            buf_we    = 1'b1;
            buf_waddr = len_q[ADDR_W-1:0];
            len_d     = len_q + LEN_ONE;
          end else begin
            err_ovf_d = 1'b1;
            state_d   = IDLE;
            len_d     = '0;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          // This idle edge is the TIMEOUT-th one in a row.
          err_tmo_d = 1'b1;
          state_d   = IDLE;
          len_d     = '0;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      DRAIN: begin
        // cmd_valid is high throughout DRAIN, so cmd_ready alone marks a beat.
        if (bus.cmd_ready) begin
          if (at_last) begin
            state_d  = IDLE;
            len_d    = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + LEN_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        len_d   = '0;
      end
    endcase
  end

  // Outputs decode only from registers, so they are all zero out of reset and
  // hold steady while the consumer stalls.
  always_comb begin
    bus.cmd_valid = (state_q == DRAIN);
    bus.cmd_last  = (state_q == DRAIN) && at_last;
    bus.cmd_char  = (state_q == DRAIN) ? buf_rdata : '0;
    bus.busy      = (state_q != IDLE);
    bus.err_ovf   = err_ovf_q;
    bus.err_tmo   = err_tmo_q;
  end

endmodule

// File: tb/tb_wake_cmd_capture.sv
// ---------------------------------------------------------------------------
// tb_wake_cmd_capture
// Directed testbench for wake_cmd_capture (MAX_LEN=16, TERM=CR, TIMEOUT=64).
// Drives the stream through the interface master side and checks outputs
// one time unit after each rising edge against hand-computed values.
// ---------------------------------------------------------------------------
module tb_wake_cmd_capture;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  wake_cmd_capture_if bus_if ();

  wake_cmd_capture #(
    .MAX_LEN (16),
    .TERM    (7'h0D),
    .TIMEOUT (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one stream beat and advance past the next rising edge.
  task automatic applyStimulus(input logic [6:0] ch, input logic vld, input logic m);
    bus_if.ascii_in  = ch;
    bus_if.ascii_vld = vld;
    bus_if.match     = m;
    @(posedge clk);
    #1;
    bus_if.ascii_vld = 1'b0;
    bus_if.match     = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(7'h00, 1'b0, 1'b0);
  endtask

  // "Alexa" with match low; match rises with the character after it.
  task automatic sendWake();
    applyStimulus(7'h41, 1'b1, 1'b0);
    applyStimulus(7'h6C, 1'b1, 1'b0);
    applyStimulus(7'h65, 1'b1, 1'b0);
    applyStimulus(7'h78, 1'b1, 1'b0);
    applyStimulus(7'h61, 1'b1, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus_if.cmd_valid), 32'd0);
    checkOutput({tag, "_last"},  32'(bus_if.cmd_last),  32'd0);
    checkOutput({tag, "_char"},  32'(bus_if.cmd_char),  32'd0);
    checkOutput({tag, "_busy"},  32'(bus_if.busy),      32'd0);
    checkOutput({tag, "_ovf"},   32'(bus_if.err_ovf),   32'd0);
    checkOutput({tag, "_tmo"},   32'(bus_if.err_tmo),   32'd0);
  endtask

  initial begin
    compared         = 0;
    mismatched       = 0;
    rst              = 1'b1;
    bus_if.ascii_in  = '0;
    bus_if.ascii_vld = 1'b0;
    bus_if.match     = 1'b0;
    bus_if.cmd_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;

    // Test 1: "on\r" with consumer always ready
    $display("[TB] test 1: basic command drain");
    bus_if.cmd_ready = 1'b1;
    sendWake();
    checkOutput("t1_busy_before_cmd", 32'(bus_if.busy), 32'd0);
    applyStimulus(7'h6F, 1'b1, 1'b1);
    checkOutput("t1_busy_capture", 32'(bus_if.busy), 32'd1);
    applyStimulus(7'h6E, 1'b1, 1'b0);
    checkOutput("t1_no_valid_in_capture", 32'(bus_if.cmd_valid), 32'd0);
    applyStimulus(7'h0D, 1'b1, 1'b0);
    checkOutput("t1_o_valid", 32'(bus_if.cmd_valid), 32'd1);
    checkOutput("t1_o_char",  32'(bus_if.cmd_char),  32'h6F);
    checkOutput("t1_o_last",  32'(bus_if.cmd_last),  32'd0);
    idleCycle();
    checkOutput("t1_n_valid", 32'(bus_if.cmd_valid), 32'd1);
    checkOutput("t1_n_char",  32'(bus_if.cmd_char),  32'h6E);
    checkOutput("t1_n_last",  32'(bus_if.cmd_last),  32'd1);
    idleCycle();
    checkOutput("t1_done_valid", 32'(bus_if.cmd_valid), 32'd0);
    checkOutput("t1_done_busy",  32'(bus_if.busy),      32'd0);

    // Test 2: same command, consumer stalls twice on the first character
    $display("[TB] test 2: stalled handshake");
    bus_if.cmd_ready = 1'b0;
    sendWake();
    applyStimulus(7'h6F, 1'b1, 1'b1);
    applyStimulus(7'h6E, 1'b1, 1'b0);
    applyStimulus(7'h0D, 1'b1, 1'b0);
    checkOutput("t2_o_valid", 32'(bus_if.cmd_valid), 32'd1);
    checkOutput("t2_o_char",  32'(bus_if.cmd_char),  32'h6F);
    idleCycle();
    checkOutput("t2_stall1_char", 32'(bus_if.cmd_char), 32'h6F);
    checkOutput("t2_stall1_last", 32'(bus_if.cmd_last), 32'd0);
    idleCycle();
    checkOutput("t2_stall2_char",  32'(bus_if.cmd_char),  32'h6F);
    checkOutput("t2_stall2_valid", 32'(bus_if.cmd_valid), 32'd1);
    bus_if.cmd_ready = 1'b1;
    idleCycle();
    checkOutput("t2_n_char", 32'(bus_if.cmd_char), 32'h6E);
    checkOutput("t2_n_last", 32'(bus_if.cmd_last), 32'd1);
    idleCycle();
    checkOutput("t2_done_valid", 32'(bus_if.cmd_valid), 32'd0);
    checkOutput("t2_done_busy",  32'(bus_if.busy),      32'd0);

    // Test 3: 17 characters overflow a 16-entry command
    $display("[TB] test 3: overflow");
    sendWake();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(7'h61 + 7'(i), 1'b1, (i == 0));
      checkOutput($sformatf("t3_no_ovf_%0d", i), 32'(bus_if.err_ovf), 32'd0);
    end
    checkOutput("t3_busy_full", 32'(bus_if.busy), 32'd1);
    applyStimulus(7'h7A, 1'b1, 1'b0);
    checkOutput("t3_ovf_pulse", 32'(bus_if.err_ovf),   32'd1);
    checkOutput("t3_ovf_busy",  32'(bus_if.busy),      32'd0);
    checkOutput("t3_ovf_valid", 32'(bus_if.cmd_valid), 32'd0);
    applyStimulus(7'h0D, 1'b1, 1'b0);
    checkOutput("t3_ovf_clear",    32'(bus_if.err_ovf),   32'd0);
    checkOutput("t3_no_valid_end", 32'(bus_if.cmd_valid), 32'd0);

    // Test 4: timeout after 64 idle cycles, then an empty command
    $display("[TB] test 4: timeout and empty command");
    sendWake();
    applyStimulus(7'h78, 1'b1, 1'b1);
    for (int i = 1; i < 64; i++) begin
      idleCycle();
      checkOutput($sformatf("t4_no_tmo_%0d", i), 32'(bus_if.err_tmo), 32'd0);
    end
    checkOutput("t4_busy_cycle63", 32'(bus_if.busy), 32'd1);
    idleCycle();
    checkOutput("t4_tmo_pulse", 32'(bus_if.err_tmo),   32'd1);
    checkOutput("t4_tmo_busy",  32'(bus_if.busy),      32'd0);
    checkOutput("t4_tmo_valid", 32'(bus_if.cmd_valid), 32'd0);
    idleCycle();
    checkOutput("t4_tmo_clear", 32'(bus_if.err_tmo), 32'd0);
    sendWake();
    applyStimulus(7'h0D, 1'b1, 1'b1);
    checkOutput("t4_empty_busy", 32'(bus_if.busy),    32'd0);
    checkOutput("t4_empty_ovf",  32'(bus_if.err_ovf), 32'd0);
    checkOutput("t4_empty_tmo",  32'(bus_if.err_tmo), 32'd0);
    idleCycle();
    checkOutput("t4_empty_valid", 32'(bus_if.cmd_valid), 32'd0);

    // Test 5: re-wake restarts the command; reset in the middle of DRAIN
    $display("[TB] test 5: re-wake and reset mid-drain");
    bus_if.cmd_ready = 1'b0;
    sendWake();
    applyStimulus(7'h61, 1'b1, 1'b1);
    applyStimulus(7'h62, 1'b1, 1'b0);
    sendWake();
    applyStimulus(7'h63, 1'b1, 1'b1);
    applyStimulus(7'h64, 1'b1, 1'b0);
    applyStimulus(7'h0D, 1'b1, 1'b0);
    checkOutput("t5_c_valid", 32'(bus_if.cmd_valid), 32'd1);
    checkOutput("t5_c_char",  32'(bus_if.cmd_char),  32'h63);
    checkOutput("t5_c_last",  32'(bus_if.cmd_last),  32'd0);
    bus_if.cmd_ready = 1'b1;
    idleCycle();
    checkOutput("t5_d_char", 32'(bus_if.cmd_char), 32'h64);
    checkOutput("t5_d_last", 32'(bus_if.cmd_last), 32'd1);
    bus_if.cmd_ready = 1'b0;
    rst = 1'b1;
    idleCycle();
    checkIdleOutputs("t5_rst");
    rst = 1'b0;
    idleCycle();
    checkOutput("t5_after_rst_valid", 32'(bus_if.cmd_valid), 32'd0);
    checkOutput("t5_after_rst_busy",  32'(bus_if.busy),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
